// File: rtl/demux1to8_buffered.sv
// Registered 1-to-8 word distributor: each accepted word lands in a one-deep slot for its
// destination channel, and every slot drains independently through its own valid/ready pair.
module demux1to8_buffered #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NCH   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_sel,
    input  logic [WIDTH-1:0]     in_data,
    output logic [NCH-1:0]       out_valid,
    input  logic [NCH-1:0]       out_ready,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [3:0]           occupancy
);

    logic [NCH-1:0]   full_q, full_d;
    logic [WIDTH-1:0] slot_q [NCH];
    logic [WIDTH-1:0] slot_d [NCH];
    logic [NCH-1:0]   acc_dec;
    logic [NCH-1:0]   drn;
    logic             acc;

    // A full slot still accepts when its consumer empties it in the same cycle.
    assign in_ready = ~full_q[in_sel] | out_ready[in_sel];
    assign acc      = in_valid & in_ready;
    assign drn      = full_q & out_ready;

    always_comb begin
        acc_dec = '0;
        if (acc) begin
            acc_dec[in_sel] = 1'b1;
        end
    end

    always_comb begin
        full_d = (full_q & ~drn) | acc_dec;
        for (int i = 0; i < NCH; i++) begin
            slot_d[i] = slot_q[i];
            if (acc_dec[i]) begin
                slot_d[i] = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            full_q <= full_d;
            for (int i = 0; i < NCH; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < NCH; i++) begin
            occupancy = occupancy + {3'b000, full_q[i]};
        end
    end

    assign out_valid = full_q;

    always_comb begin
        out_data = '0;
        for (int i = 0; i < NCH; i++) begin
            out_data[i*WIDTH +: WIDTH] = slot_q[i];
        end
    end

endmodule
